// File: rtl/axi_lite_mem_master.sv
// AXI4-Lite initiator: one CPU request at a time becomes one AXI-Lite read or write transaction.
// Optional feature: define AXI_MST_PERF_CNT_EN to add completed-read/write and wait-cycle counters.
module axi_lite_mem_master #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
`ifdef AXI_MST_PERF_CNT_EN
  ,
  output logic [31:0]           perf_rd_cnt,
  output logic [31:0]           perf_wr_cnt,
  output logic [31:0]           perf_wait_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [31:0]           r_wdata, w_wdata_nxt;
  logic [3:0]            r_wstrb, w_wstrb_nxt;
  logic                  r_arvalid, w_arvalid_nxt;
  logic                  r_rready, w_rready_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic                  r_wvalid, w_wvalid_nxt;
  logic                  r_bready, w_bready_nxt;
  logic                  r_resp_valid, w_resp_valid_nxt;
  logic [31:0]           r_resp_rdata, w_resp_rdata_nxt;
  logic                  r_resp_err, w_resp_err_nxt;
  logic                  w_aw_done, w_w_done;
  logic                  w_unused;

  // Address LSBs and the low response bit carry no meaning for this initiator.
  assign w_unused = ^{req_addr[1:0], m_axi_bresp[0], m_axi_rresp[0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wstrb      <= w_wstrb_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_rready     <= w_rready_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_bready     <= w_bready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
    end
  end

  // A write channel counts as done once its valid is already low or handshakes this cycle.
  assign w_aw_done = !r_awvalid || m_axi_awready;
  assign w_w_done  = !r_wvalid  || m_axi_wready;

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_wstrb_nxt      = r_wstrb;
    w_arvalid_nxt    = r_arvalid;
    w_rready_nxt     = r_rready;
    w_awvalid_nxt    = r_awvalid;
    w_wvalid_nxt     = r_wvalid;
    w_bready_nxt     = r_bready;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_addr_nxt  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          w_wdata_nxt = req_wdata;
          w_wstrb_nxt = req_wstrb;
          if (req_wen) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = S_WR;
          end else begin
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = S_AR;
          end
        end
      end
      S_AR: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_R;
        end
      end
      S_R: begin
        if (m_axi_rvalid) begin
          w_resp_rdata_nxt = m_axi_rdata;
          w_resp_err_nxt   = m_axi_rresp[1];
          w_rready_nxt     = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = S_RESP;
        end
      end
      S_WR: begin
        if (r_awvalid && m_axi_awready) w_awvalid_nxt = 1'b0;
        if (r_wvalid && m_axi_wready)   w_wvalid_nxt  = 1'b0;
        if (w_aw_done && w_w_done) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_B;
        end
      end
      S_B: begin
        if (m_axi_bvalid) begin
          w_resp_rdata_nxt = '0;
          w_resp_err_nxt   = m_axi_bresp[1];
          w_bready_nxt     = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign req_ready     = (r_state == S_IDLE);
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;

`ifdef AXI_MST_PERF_CNT_EN
  logic        r_wen;
  logic [31:0] r_perf_rd, r_perf_wr, r_perf_wait;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wen       <= 1'b0;
      r_perf_rd   <= '0;
      r_perf_wr   <= '0;
      r_perf_wait <= '0;
    end else begin
      if (r_state == S_IDLE && req_valid) r_wen <= req_wen;
      if (r_state == S_RESP) begin
        if (r_wen) r_perf_wr <= r_perf_wr + 32'd1;
        else       r_perf_rd <= r_perf_rd + 32'd1;
      end
      if (r_state == S_AR || r_state == S_R || r_state == S_WR || r_state == S_B)
        r_perf_wait <= r_perf_wait + 32'd1;
    end
  end

  assign perf_rd_cnt   = r_perf_rd;
  assign perf_wr_cnt   = r_perf_wr;
  assign perf_wait_cnt = r_perf_wait;
`endif

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Scoreboard bench for axi_lite_mem_master with a behavioural AXI-Lite slave of configurable ready delays.
module tb_axi_lite_mem_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [13:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [13:0] m_axi_araddr, m_axi_awaddr;
  logic        m_axi_arvalid, m_axi_arready, m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready, m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
`ifdef AXI_MST_PERF_CNT_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_wait_cnt;
`endif

  always #5 clk = ~clk;

  axi_lite_mem_master #(.ADDR_WIDTH(14)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
`ifdef AXI_MST_PERF_CNT_EN
    , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // slave configuration, set by the stimulus before each request
  int          ar_wait = 0, aw_wait = 0, w_wait = 0;
  logic [31:0] slv_rdata = '0;
  logic [1:0]  slv_rresp = '0, slv_bresp = '0;

  // random input override used while reset is held
  logic        rnd_mode = 1'b0;
  logic        rnd_arready = 0, rnd_awready = 0, rnd_wready = 0, rnd_bvalid = 0, rnd_rvalid = 0;
  logic [31:0] rnd_rdata = '0;
  logic [1:0]  rnd_bresp = '0, rnd_rresp = '0;

  int          ar_cnt, aw_cnt, w_cnt;
  logic        s_rvalid, s_bvalid, aw_got, w_got;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;
  logic        aw_now, w_now;

  assign m_axi_arready = rnd_mode ? rnd_arready : (m_axi_arvalid && ar_cnt >= ar_wait);
  assign m_axi_awready = rnd_mode ? rnd_awready : (m_axi_awvalid && aw_cnt >= aw_wait);
  assign m_axi_wready  = rnd_mode ? rnd_wready  : (m_axi_wvalid && w_cnt >= w_wait);
  assign m_axi_rvalid  = rnd_mode ? rnd_rvalid  : s_rvalid;
  assign m_axi_rdata   = rnd_mode ? rnd_rdata   : s_rdata;
  assign m_axi_rresp   = rnd_mode ? rnd_rresp   : s_rresp;
  assign m_axi_bvalid  = rnd_mode ? rnd_bvalid  : s_bvalid;
  assign m_axi_bresp   = rnd_mode ? rnd_bresp   : s_bresp;
  assign aw_now = aw_got || (m_axi_awvalid && m_axi_awready);
  assign w_now  = w_got  || (m_axi_wvalid && m_axi_wready);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
      s_rvalid <= 1'b0; s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      s_rdata <= '0; s_rresp <= '0; s_bresp <= '0;
    end else begin
      ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      if (m_axi_arvalid && m_axi_arready) begin
        s_rvalid <= 1'b1; s_rdata <= slv_rdata; s_rresp <= slv_rresp;
      end else if (s_rvalid && m_axi_rready) begin
        s_rvalid <= 1'b0;
      end
      if (s_bvalid && m_axi_bready) begin
        s_bvalid <= 1'b0;
      end else if (aw_now && w_now && !s_bvalid) begin
        s_bvalid <= 1'b1; s_bresp <= slv_bresp; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_now; w_got <= w_now;
      end
    end
  end

  typedef struct {
    logic        wen;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [13:0] ar_q[$], aw_q[$];
  logic [35:0] w_q[$];
  int          cyc = 0, acc_cnt = 0, ar_hs = 0, resp_cnt = 0, rd_done = 0, wr_done = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (resetn && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  // monitor: protocol holds, address/data scoreboards and response scoreboard
  logic        p_arvalid = 0, p_arready = 0, p_awvalid = 0, p_awready = 0, p_wvalid = 0, p_wready = 0;
  logic [13:0] p_araddr = '0, p_awaddr = '0;
  logic [35:0] p_wpay = '0;
  always begin
    @(negedge clk);
    #2;
    if (!resetn) begin
      p_arvalid = 0; p_awvalid = 0; p_wvalid = 0;
      rd_done = 0; wr_done = 0;
    end else begin
      if (p_arvalid && !p_arready) begin
        chk("ar_hold", m_axi_arvalid, 1);
        chk("ar_stable", m_axi_araddr, p_araddr);
      end
      if (p_awvalid && !p_awready) begin
        chk("aw_hold", m_axi_awvalid, 1);
        chk("aw_stable", m_axi_awaddr, p_awaddr);
      end
      if (p_wvalid && !p_wready) begin
        chk("w_hold", m_axi_wvalid, 1);
        chk("w_stable", {m_axi_wstrb, m_axi_wdata}, p_wpay);
      end
      if (m_axi_arvalid && m_axi_arready) begin
        ar_hs++;
        if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
        else chk("araddr", m_axi_araddr, ar_q.pop_front());
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("awaddr", m_axi_awaddr, aw_q.pop_front());
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_q.size() == 0) chk("w_unexpected", 1, 0);
        else chk("wpayload", {m_axi_wstrb, m_axi_wdata}, w_q.pop_front());
      end
      if (resp_valid) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.wen) wr_done++; else rd_done++;
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", resp_err, e.err);
          if (e.lat >= 0) chk("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
      p_arvalid = m_axi_arvalid; p_arready = m_axi_arready; p_araddr = m_axi_araddr;
      p_awvalid = m_axi_awvalid; p_awready = m_axi_awready; p_awaddr = m_axi_awaddr;
      p_wvalid = m_axi_wvalid; p_wready = m_axi_wready; p_wpay = {m_axi_wstrb, m_axi_wdata};
    end
  end

  task automatic do_req(input logic wen, input logic [13:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    e.wen   = wen;
    e.rdata = wen ? 32'h0 : slv_rdata;
    e.err   = wen ? slv_bresp[1] : slv_rresp[1];
    e.acc   = cyc;
    e.lat   = lat;
    exp_q.push_back(e);
    if (wen) begin
      aw_q.push_back({addr[13:2], 2'b00});
      w_q.push_back({ws, wd});
    end else begin
      ar_q.push_back({addr[13:2], 2'b00});
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 0);
      exp_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete();
    end
  endtask

  task automatic set_slave(input int arw, input int aww, input int ww, input logic [31:0] rd,
                           input logic [1:0] rr, input logic [1:0] br);
    ar_wait = arw; aw_wait = aww; w_wait = ww; slv_rdata = rd; slv_rresp = rr; slv_bresp = br;
  endtask

  initial begin
    int n, base_ar, base_resp, base_acc;

    // reset with random AXI inputs
    rnd_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rnd_arready = 1'($urandom); rnd_awready = 1'($urandom); rnd_wready = 1'($urandom);
      rnd_bvalid = 1'($urandom); rnd_rvalid = 1'($urandom); rnd_rdata = $urandom;
      rnd_bresp = 2'($urandom); rnd_rresp = 2'($urandom);
      req_valid = 1'($urandom);
      #1;
      chk("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_rready}, 0);
      chk("rst_resp", {resp_valid, resp_err, resp_rdata}, 0);
      chk("rst_req_ready", req_ready, 1);
    end
    @(negedge clk);
    rnd_mode = 1'b0; req_valid = 1'b0;
    resetn = 1'b1;

    // zero-wait read with latency check
    set_slave(0, 0, 0, 32'hDEADBEEF, 2'b00, 2'b00);
    do_req(1'b0, 14'h0104, 32'h0, 4'h0, 2);
    wait_done();

    // write where W completes two cycles before AW
    set_slave(0, 2, 0, 32'h0, 2'b00, 2'b00);
    do_req(1'b1, 14'h0010, 32'h12345678, 4'h3, -1);
    @(negedge clk);
    #1;
    chk("w_first_wvalid", m_axi_wvalid, 0);
    chk("w_first_awvalid", m_axi_awvalid, 1);
    chk("w_first_bready", m_axi_bready, 0);
    n = 0;
    while (!m_axi_bready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("b_after_aw", {m_axi_bready, m_axi_awvalid, m_axi_wvalid}, 3'b100);
    wait_done();

    // misaligned read with SLVERR
    set_slave(1, 0, 0, 32'hCAFEF00D, 2'b10, 2'b00);
    do_req(1'b0, 14'h0107, 32'h0, 4'h0, -1);
    wait_done();

    // write with AW before W and an error response
    set_slave(0, 0, 3, 32'h0, 2'b00, 2'b11);
    do_req(1'b1, 14'h3FFE, 32'hA5A5_0F0F, 4'hC, -1);
    wait_done();

    // mixed random traffic
    for (int i = 0; i < 16; i++) begin
      set_slave(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                $urandom, 2'($urandom), 2'($urandom));
      do_req(1'($urandom), 14'($urandom), $urandom, 4'($urandom), -1);
      wait_done();
    end

    // back-to-back reads with req_valid held high
    set_slave(0, 0, 0, 32'h11223344, 2'b00, 2'b00);
    base_ar = ar_hs; base_resp = resp_cnt; base_acc = acc_cnt;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.wen = 1'b0; e.rdata = 32'h11223344; e.err = 1'b0; e.acc = 0; e.lat = -1;
      exp_q.push_back(e);
      ar_q.push_back(14'h0040);
    end
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 14'h0041;
    n = 0;
    while (acc_cnt - base_acc < 2 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("b2b_accepts", 64'(acc_cnt - base_acc), 2);
    chk("b2b_second_after_resp", 64'(resp_cnt - base_resp), 1);
    req_valid = 1'b0;
    wait_done();
    chk("b2b_ar_count", 64'(ar_hs - base_ar), 2);
`ifdef AXI_MST_PERF_CNT_EN
    @(negedge clk);
    chk("perf_rd", perf_rd_cnt, 64'(rd_done));
    chk("perf_wr", perf_wr_cnt, 64'(wr_done));
`endif

    // reset pulse while waiting in R
    set_slave(0, 0, 0, 32'h55AA55AA, 2'b00, 2'b00);
    do_req(1'b0, 14'h0200, 32'h0, 4'h0, -1);
    n = 0;
    while (!m_axi_rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_r_state", m_axi_rready, 1);
    resetn = 1'b0;
    #1;
    chk("midrst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_rready}, 0);
    chk("midrst_resp", {resp_valid, resp_err, resp_rdata}, 0);
    chk("midrst_req_ready", req_ready, 1);
    exp_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    set_slave(0, 0, 0, 32'h0BADCAFE, 2'b00, 2'b00);
    do_req(1'b0, 14'h0208, 32'h0, 4'h0, 2);
    wait_done();

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
